seq_mult_param: RTL and testbench

- Parametrised shift-add sequential multiplier; successor to the fixed 6-bit unsigned right-shift multiplier.
- Generalises operand width to WIDTH.
- Adds a per-operation signed/unsigned mode and an explicit busy/done handshake.
- Product is held in a dedicated result register so the output is stable between operations.
- Standalone arithmetic unit for datapaths that can tolerate WIDTH-cycle latency in exchange for minimal area.

---
 rtl/seq_mult_param.sv | 142 ++++++++++++++
 tb/tb_seq_mult_param.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_mult_param.sv
// seq_mult_param: shift-add sequential multiplier, WIDTH-bit operands,
// 2*WIDTH-bit product, per-operation signed/unsigned mode.
// Ports: clk, rst (sync, active-low), load/sgn/a/b start an operation;
// product holds the last result, busy marks RUN, done pulses once,
// count reports multiplier bits processed.
// Optional build macro SEQ_MULT_EARLY_TERM_EN: finish as soon as the
// remaining multiplier bits are all zero.
module seq_mult_param #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 sgn,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy,
  output logic                 done,
  output logic [CW-1:0]        count
);

  localparam int W  = WIDTH;
  localparam int PW = 2 * W + 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t          state_q, state_d;
  logic [W:0]      mcand_q, mcand_d;
  logic [W:0]      acc_q, acc_d;
  logic [W-1:0]    mplr_q, mplr_d;
  logic            sgn_q, sgn_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2*W-1:0]  prod_q, prod_d;
  logic            done_q, done_d;

  logic            sub;
  logic [W:0]      sum;
  logic [PW-1:0]   step;
  logic [PW-1:0]   fin;
  logic            finish;
`ifdef SEQ_MULT_EARLY_TERM_EN
  logic [W-1:0]    hi_mask;
  logic [CW-1:0]   rem;
  logic signed [PW-1:0] step_s;
`endif

  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    mplr_d  = mplr_q;
    sgn_d   = sgn_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    done_d  = 1'b0;

    // Signed MSB carries negative weight, so it is subtracted.
    sub = sgn_q && (cnt_q == CW'(W - 1));
    sum = acc_q;
    if (mplr_q[0]) begin
      sum = sub ? (acc_q - mcand_q) : (acc_q + mcand_q);
    end
    step = {sgn_q & sum[W], sum, mplr_q[W-1:1]};

`ifdef SEQ_MULT_EARLY_TERM_EN
    // Bits above the one consumed this cycle; zero means nothing
    // left to add, so the rest is a plain multi-bit shift.
    hi_mask = {W{1'b1}} >> (cnt_q + CW'(1));
    finish  = (cnt_q == CW'(W - 1))
           || (((mplr_q >> 1) & hi_mask) == '0);
    rem     = CW'(W - 1) - cnt_q;
    step_s  = step;
    if (sgn_q) begin
      fin = step_s >>> rem;
    end else begin
      fin = step >> rem;
    end
`else
    finish = (cnt_q == CW'(W - 1));
    fin    = step;
`endif

    case (state_q)
      IDLE, DONE: begin
        if (load) begin
          mcand_d = {sgn & a[W-1], a};
          acc_d   = '0;
          mplr_d  = b;
          sgn_d   = sgn;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d  = fin[PW-1:W];
        mplr_d = fin[W-1:0];
        cnt_d  = cnt_q + CW'(1);
        if (finish) begin
          cnt_d   = CW'(W);
          prod_d  = fin[2*W-1:0];
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      mcand_q <= '0;
      acc_q   <= '0;
      mplr_q  <= '0;
      sgn_q   <= 1'b0;
      cnt_q   <= '0;
      prod_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      mplr_q  <= mplr_d;
      sgn_q   <= sgn_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      done_q  <= done_d;
    end
  end

  assign product = prod_q;
  assign busy    = (state_q == RUN);
  assign done    = done_q;
  assign count   = cnt_q;

endmodule

// File: tb/tb_seq_mult_param.sv
// tb_seq_mult_param: scoreboard bench for seq_mult_param at
// WIDTH 6 (directed), 8 and 16 (random against a behavioural multiply).
module tb_seq_mult_param;

  typedef struct {
    string       name;
    logic [31:0] p;
    int          t;
    int          lat;
  } exp_t;

  exp_t q6[$];
  exp_t q8[$];
  exp_t q16[$];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic        load6 = 0, sgn6 = 0;
  logic [5:0]  a6 = 0, b6 = 0;
  logic [11:0] p6;
  logic        busy6, done6;
  logic [2:0]  cnt6;

  logic        load8 = 0, sgn8 = 0;
  logic [7:0]  a8 = 0, b8 = 0;
  logic [15:0] p8;
  logic        busy8, done8;
  logic [3:0]  cnt8;

  logic        load16 = 0, sgn16 = 0;
  logic [15:0] a16 = 0, b16 = 0;
  logic [31:0] p16;
  logic        busy16, done16;
  logic [4:0]  cnt16;

  seq_mult_param #(.WIDTH(6)) u6 (
    .clk(clk), .rst(rst), .load(load6), .sgn(sgn6),
    .a(a6), .b(b6), .product(p6), .busy(busy6),
    .done(done6), .count(cnt6)
  );

  seq_mult_param #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .load(load8), .sgn(sgn8),
    .a(a8), .b(b8), .product(p8), .busy(busy8),
    .done(done8), .count(cnt8)
  );

  seq_mult_param #(.WIDTH(16)) u16 (
    .clk(clk), .rst(rst), .load(load16), .sgn(sgn16),
    .a(a16), .b(b16), .product(p16), .busy(busy16),
    .done(done16), .count(cnt16)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lat_of(int w, logic [31:0] bv);
    int l;
    l = w;
`ifdef SEQ_MULT_EARLY_TERM_EN
    l = 1;
    for (int i = 0; i < w; i++) begin
      if (bv[i]) l = i + 1;
    end
`endif
    return l;
  endfunction

  function automatic logic [31:0] mul_ref(int w, logic s,
                                          logic [31:0] av,
                                          logic [31:0] bv);
    longint sa, sb, r, m;
    sa = longint'(av);
    sb = longint'(bv);
    if (s && av[w-1]) sa = sa - (longint'(1) << w);
    if (s && bv[w-1]) sb = sb - (longint'(1) << w);
    r = sa * sb;
    m = (longint'(1) << (2 * w)) - 1;
    return 32'(r & m);
  endfunction

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  function automatic int qsize(int w);
    case (w)
      6:       return q6.size();
      8:       return q8.size();
      default: return q16.size();
    endcase
  endfunction

  task automatic check_pop(int w, logic [31:0] p, int c, logic bz);
    exp_t e;
    bit   ok;
    ok = 0;
    case (w)
      6:  if (q6.size() > 0)  begin e = q6.pop_front();  ok = 1; end
      8:  if (q8.size() > 0)  begin e = q8.pop_front();  ok = 1; end
      16: if (q16.size() > 0) begin e = q16.pop_front(); ok = 1; end
      default: ;
    endcase
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL w%0d unexpected done: product %0h", w, p);
    end else begin
      chk({e.name, " product"}, p, e.p);
      chk({e.name, " latency"}, 32'(cyc - e.t), 32'(e.lat));
      chk({e.name, " count"}, 32'(c), 32'(w));
      chk({e.name, " busy"}, 32'(bz), 32'(0));
    end
  endtask

  always @(negedge clk) if (rst && done6)
    check_pop(6, 32'(p6), int'(cnt6), busy6);
  always @(negedge clk) if (rst && done8)
    check_pop(8, 32'(p8), int'(cnt8), busy8);
  always @(negedge clk) if (rst && done16)
    check_pop(16, p16, int'(cnt16), busy16);

  task automatic drain(int w, int budget);
    int g;
    g = 0;
    while (qsize(w) != 0 && g < budget) begin
      @(negedge clk);
      g++;
    end
    if (qsize(w) != 0) begin
      tests++;
      fails++;
      $display("FAIL w%0d timeout: %0d results pending", w, qsize(w));
      case (w)
        6:       q6.delete();
        8:       q8.delete();
        default: q16.delete();
      endcase
    end
  endtask

  task automatic issue6(string n, logic [5:0] av, logic [5:0] bv,
                        logic s, logic [11:0] e);
    @(negedge clk);
    load6 = 1; a6 = av; b6 = bv; sgn6 = s;
    @(posedge clk);
    #1;
    q6.push_back('{n, 32'(e), cyc, lat_of(6, 32'(bv))});
    load6 = 0; a6 = ~av; b6 = ~bv; sgn6 = ~s;
  endtask

  initial begin
    int g;
    rst = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset product", 32'(p6), 32'(0));
    chk("reset busy", 32'(busy6), 32'(0));
    chk("reset done", 32'(done6), 32'(0));
    chk("reset count", 32'(cnt6), 32'(0));
    rst = 1;

    issue6("u 57x32", 6'd57, 6'd32, 0, 12'd1824); drain(6, 20);
    issue6("u 11x12", 6'd11, 6'd12, 0, 12'd132);  drain(6, 20);
    issue6("u 63x62", 6'd63, 6'd62, 0, 12'd3906); drain(6, 20);
    issue6("s -5x7", 6'b111011, 6'd7, 1, 12'hFDD); drain(6, 20);
    issue6("s -32x-32", 6'b100000, 6'b100000, 1, 12'd1024);
    drain(6, 20);
    issue6("s 5x-1", 6'd5, 6'b111111, 1, 12'hFFB); drain(6, 20);
    issue6("u 17x0", 6'd17, 6'd0, 0, 12'd0);       drain(6, 20);
    issue6("u 17x4", 6'd17, 6'd4, 0, 12'd68);      drain(6, 20);

    // load held during RUN must be ignored
    issue6("hold 57x32", 6'd57, 6'd32, 0, 12'd1824);
    load6 = 1; a6 = 6'd1; b6 = 6'd1;
    repeat (3) @(posedge clk);
    #1;
    chk("hold count", 32'(cnt6), 32'(3));
    load6 = 0;
    drain(6, 20);

    // back-to-back: load in the DONE cycle
    issue6("b2b 11x12", 6'd11, 6'd12, 0, 12'd132);
    g = 0;
    while (!done6 && g < 20) begin
      @(negedge clk);
      g++;
    end
    if (!done6) begin
      tests++; fails++;
      $display("FAIL b2b: done never seen");
    end
    load6 = 1; a6 = 6'd63; b6 = 6'd62; sgn6 = 0;
    @(posedge clk);
    #1;
    q6.push_back('{"b2b 63x62", 32'd3906, cyc, lat_of(6, 32'd62)});
    load6 = 0;
    chk("b2b busy", 32'(busy6), 32'(1));
    chk("b2b held product", 32'(p6), 32'd132);
    drain(6, 20);

    // reset in the middle of an operation
    @(negedge clk);
    load6 = 1; a6 = 6'd11; b6 = 6'd12; sgn6 = 0;
    @(posedge clk);
    #1;
    load6 = 0;
    g = 0;
    while (cnt6 != 3'd3 && g < 10) begin
      @(negedge clk);
      g++;
    end
    rst = 0;
    @(posedge clk);
    #1;
    chk("midrst product", 32'(p6), 32'(0));
    chk("midrst busy", 32'(busy6), 32'(0));
    chk("midrst done", 32'(done6), 32'(0));
    chk("midrst count", 32'(cnt6), 32'(0));
    rst = 1;
    issue6("post-rst 11x12", 6'd11, 6'd12, 0, 12'd132);
    drain(6, 20);

    fork
      for (int i = 0; i < 1000; i++) begin
        @(negedge clk);
        load8 = 1;
        a8 = 8'($urandom); b8 = 8'($urandom);
        sgn8 = 1'($urandom_range(0, 1));
        if (i == 0) begin a8 = 8'h80; b8 = 8'h80; sgn8 = 1; end
        if (i == 1) begin a8 = 8'hFF; b8 = 8'hFF; sgn8 = 0; end
        @(posedge clk);
        #1;
        q8.push_back('{"rand8", mul_ref(8, sgn8, 32'(a8), 32'(b8)),
                       cyc, lat_of(8, 32'(b8))});
        load8 = 0; a8 = ~a8; b8 = ~b8; sgn8 = ~sgn8;
        drain(8, 30);
      end
      for (int i = 0; i < 1000; i++) begin
        @(negedge clk);
        load16 = 1;
        a16 = 16'($urandom); b16 = 16'($urandom);
        sgn16 = 1'($urandom_range(0, 1));
        if (i == 0) begin a16 = 16'h8000; b16 = 16'h8000; sgn16 = 1; end
        if (i == 1) begin a16 = 16'hFFFF; b16 = 16'hFFFF; sgn16 = 0; end
        @(posedge clk);
        #1;
        q16.push_back('{"rand16", mul_ref(16, sgn16, 32'(a16), 32'(b16)),
                        cyc, lat_of(16, 32'(b16))});
        load16 = 0; a16 = ~a16; b16 = ~b16; sgn16 = ~sgn16;
        drain(16, 40);
      end
    join

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
